seg7_scan_driver: RTL

//  Multiplexed N-digit 7-segment display driver. Sits downstream of the b27s

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_scan_driver_b27s.sv | 27 ++
 rtl/seg7_scan_driver.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are {dp,g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;

  localparam int DP_BIT = 7;

  // Counter width helper; a 1-state counter still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_b27s.sv
// b27s: 4-bit code to 7-segment {g..a} decoder.
// Codes 10-15 are not displayable and decode to all-off.
module b27s
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK[6:0];
    unique case (code)
      4'd0:    seg = SEG_0[6:0];
      4'd1:    seg = SEG_1[6:0];
      4'd2:    seg = SEG_2[6:0];
      4'd3:    seg = SEG_3[6:0];
      4'd4:    seg = SEG_4[6:0];
      4'd5:    seg = SEG_5[6:0];
      4'd6:    seg = SEG_6[6:0];
      4'd7:    seg = SEG_7[6:0];
      4'd8:    seg = SEG_8[6:0];
      4'd9:    seg = SEG_9[6:0];
      default: seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with a double-buffered
// digit word, leading-zero suppression and anti-ghost blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_en,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_start,
  output logic                  pending
);

  localparam int CNT_W = cnt_w(PRESCALE);
  localparam int IDX_W = cnt_w(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] disp_data;
  logic [N_DIGITS-1:0]   disp_dp;
  logic [4*N_DIGITS-1:0] pend_data;
  logic [N_DIGITS-1:0]   pend_dp;

  logic                  slot_end;
  logic                  boundary;
  logic                  blank;
  logic [3:0]            nib;
  logic                  dp_cur;
  logic                  sup_cur;
  logic [N_DIGITS-1:0]   onehot;
  logic [N_DIGITS-1:0]   sup;
  logic [6:0]            dec;

  assign slot_end = (cnt == CNT_MAX);
  assign boundary = slot_end && (idx == IDX_MAX);
  assign blank    = (int'(cnt) < BLANK_CYCLES);

  // A digit is suppressed when it and every more significant digit is 0.
  always_comb begin
    logic zero_run;
    zero_run = lz_en;
    sup      = '0;
    nib      = 4'd0;
    dp_cur   = 1'b0;
    sup_cur  = 1'b0;
    onehot   = '0;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      zero_run = zero_run && (disp_data[4*d +: 4] == 4'd0);
      sup[d]   = zero_run && (d != 0);
    end
    for (int d = 0; d < N_DIGITS; d++) begin
      if (idx == IDX_W'(d)) begin
        nib       = disp_data[4*d +: 4];
        dp_cur    = disp_dp[d];
        sup_cur   = sup[d];
        onehot[d] = 1'b1;
      end
    end
  end

  b27s u_b27s (
    .code (nib),
    .seg  (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      seg         <= SEG_BLANK;
      an          <= '0;
      frame_start <= 1'b0;
      pending     <= 1'b0;
      disp_data   <= '0;
      disp_dp     <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      an          <= blank ? '0 : onehot;
      seg         <= blank ? SEG_BLANK
                           : {dp_cur, (sup_cur ? 7'd0 : dec)};
      frame_start <= boundary;

      if (boundary && pending) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end

      // A load on the boundary keeps pending set for the next frame.
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        pending   <= 1'b1;
      end else if (boundary) begin
        pending   <= 1'b0;
      end
    end
  end

endmodule
